// File: rtl/vga_cursor_overlay_if.sv
// Pixel/cursor bus between the sync generator, the mouse controller and the
// cursor overlay. The overlay attaches through the slave modport.
interface vga_cursor_overlay_if;
   logic        pixel_tick;
   logic        video_on;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic [9:0]  cursor_x;
   logic [9:0]  cursor_y;
   logic [2:0]  buttons;
   logic        cursor_valid;
   logic [11:0] rgb;
   logic        frame_commit;

   modport master (
      output pixel_tick,
      output video_on,
      output pixel_x,
      output pixel_y,
      output cursor_x,
      output cursor_y,
      output buttons,
      output cursor_valid,
      input  rgb,
      input  frame_commit
   );

   modport slave (
      input  pixel_tick,
      input  video_on,
      input  pixel_x,
      input  pixel_y,
      input  cursor_x,
      input  cursor_y,
      input  buttons,
      input  cursor_valid,
      output rgb,
      output frame_commit
   );
endinterface

// File: rtl/vga_cursor_overlay.sv
// 64-pixel grid background with a 16x16 arrow cursor, tear-free cursor updates
// committed at the start of vertical blanking. Optional crosshair: VGA_CURSOR_CROSSHAIR_EN.
module vga_cursor_overlay #(
   parameter logic [11:0] BG_COLOR      = 12'h000,
   parameter logic [11:0] GRID_COLOR    = 12'h444,
   parameter logic [11:0] FILL_COLOR    = 12'hFFF,
   parameter logic [11:0] FILL_PRESSED  = 12'hF00,
   parameter logic [11:0] OUTLINE_COLOR = 12'h000
) (
   input logic                 clk,
   input logic                 rst_n,
   vga_cursor_overlay_if.slave bus
);

   localparam logic [9:0] MAX_X    = 10'd639;
   localparam logic [9:0] MAX_Y    = 10'd479;
   localparam logic [9:0] COMMIT_Y = 10'd480;
   localparam logic [9:0] HOME_X   = 10'd320;
   localparam logic [9:0] HOME_Y   = 10'd240;
   localparam logic [9:0] SPRITE_N = 10'd16;

   // Sprite masks, leftmost pixel in bit 15.
   function automatic logic [15:0] outline_row(input logic [3:0] row);
      logic [15:0] bits;
      case (row)
         4'd0:    bits = 16'h8000;
         4'd1:    bits = 16'hC000;
         4'd2:    bits = 16'hA000;
         4'd3:    bits = 16'h9000;
         4'd4:    bits = 16'h8800;
         4'd5:    bits = 16'h8400;
         4'd6:    bits = 16'h8200;
         4'd7:    bits = 16'h8100;
         4'd8:    bits = 16'h8080;
         4'd9:    bits = 16'h8040;
         4'd10:   bits = 16'h83E0;
         4'd11:   bits = 16'h9200;
         4'd12:   bits = 16'hA900;
         4'd13:   bits = 16'hC480;
         4'd14:   bits = 16'h8240;
         4'd15:   bits = 16'h0180;
         default: bits = 16'h0000;
      endcase
      return bits;
   endfunction

   function automatic logic [15:0] fill_row(input logic [3:0] row);
      logic [15:0] bits;
      case (row)
         4'd2:    bits = 16'h4000;
         4'd3:    bits = 16'h6000;
         4'd4:    bits = 16'h7000;
         4'd5:    bits = 16'h7800;
         4'd6:    bits = 16'h7C00;
         4'd7:    bits = 16'h7E00;
         4'd8:    bits = 16'h7F00;
         4'd9:    bits = 16'h7F80;
         4'd10:   bits = 16'h7C00;
         4'd11:   bits = 16'h6C00;
         4'd12:   bits = 16'h4600;
         4'd13:   bits = 16'h0300;
         4'd14:   bits = 16'h0180;
         default: bits = 16'h0000;
      endcase
      return bits;
   endfunction

   // 2-bit pixel code: 00 transparent, 01 outline, 10 fill.
   function automatic logic [1:0] cursor_rom(input logic [3:0] row, input logic [3:0] col);
      logic [15:0] o_bits;
      logic [15:0] f_bits;
      logic [3:0]  idx;
      o_bits = outline_row(row);
      f_bits = fill_row(row);
      idx    = 4'd15 - col;
      return {f_bits[idx], o_bits[idx]};
   endfunction

   function automatic logic [9:0] clamp10(input logic [9:0] value, input logic [9:0] limit);
      return (value > limit) ? limit : value;
   endfunction

   logic [9:0]  pend_x_r;
   logic [9:0]  pend_y_r;
   logic [2:0]  pend_btn_r;
   logic        pend_dirty_r;
   logic [9:0]  act_x_r;
   logic [9:0]  act_y_r;
   logic [2:0]  act_btn_r;
   logic [11:0] rgb_r;
   logic        frame_commit_r;

   logic [9:0]  render_col_s;
   logic [9:0]  render_row_s;
   logic [9:0]  dx_s;
   logic [9:0]  dy_s;
   logic        in_sprite_s;
   logic [1:0]  sprite_code_s;
   logic [11:0] bg_s;
   logic [11:0] under_s;
   logic [11:0] fill_s;
   logic [11:0] composite_s;
   logic        commit_pt_s;
   logic        commit_take_s;

   // The output register adds one tick, so render the column about to be shown.
   assign render_col_s  = bus.pixel_x + 10'd1;
   assign render_row_s  = bus.pixel_y;
   assign dx_s          = render_col_s - act_x_r;
   assign dy_s          = render_row_s - act_y_r;
   assign in_sprite_s   = (dx_s < SPRITE_N) && (dy_s < SPRITE_N);
   assign sprite_code_s = cursor_rom(dy_s[3:0], dx_s[3:0]);
   assign fill_s        = (act_btn_r != 3'd0) ? FILL_PRESSED : FILL_COLOR;

   assign commit_pt_s   = bus.pixel_tick && (bus.pixel_x == 10'd0) && (bus.pixel_y == COMMIT_Y);
   assign commit_take_s = commit_pt_s && pend_dirty_r;

   // Background grid and optional crosshair layer.
   always_comb begin
      bg_s = BG_COLOR;
      if ((render_col_s[5:0] == 6'd0) || (render_row_s[5:0] == 6'd0)) begin
         bg_s = GRID_COLOR;
      end else begin
         bg_s = BG_COLOR;
      end
      under_s = bg_s;
`ifdef VGA_CURSOR_CROSSHAIR_EN
      if ((render_col_s == act_x_r) || (render_row_s == act_y_r)) begin
         under_s = ~bg_s;
      end else begin
         under_s = bg_s;
      end
`endif
   end

   // Cursor sprite composited over the lower layers.
   always_comb begin
      composite_s = under_s;
      if (in_sprite_s) begin
         case (sprite_code_s)
            2'b01:   composite_s = OUTLINE_COLOR;
            2'b10:   composite_s = fill_s;
            default: composite_s = under_s;
         endcase
      end else begin
         composite_s = under_s;
      end
   end

   // Pending registers; a strobe on the commit tick still lands here and stays dirty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_x_r     <= HOME_X;
         pend_y_r     <= HOME_Y;
         pend_btn_r   <= 3'd0;
         pend_dirty_r <= 1'b0;
      end else if (bus.cursor_valid) begin
         pend_x_r     <= clamp10(bus.cursor_x, MAX_X);
         pend_y_r     <= clamp10(bus.cursor_y, MAX_Y);
         pend_btn_r   <= bus.buttons;
         pend_dirty_r <= 1'b1;
      end else if (commit_take_s) begin
         pend_dirty_r <= 1'b0;
      end
   end

   // Active registers, updated only at the start of vertical blanking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_x_r   <= HOME_X;
         act_y_r   <= HOME_Y;
         act_btn_r <= 3'd0;
      end else if (commit_take_s) begin
         act_x_r   <= pend_x_r;
         act_y_r   <= pend_y_r;
         act_btn_r <= pend_btn_r;
      end
   end

   // Registered pixel output and commit pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_r          <= 12'h000;
         frame_commit_r <= 1'b0;
      end else begin
         frame_commit_r <= commit_take_s;
         if (bus.pixel_tick) begin
            rgb_r <= bus.video_on ? composite_s : 12'h000;
         end
      end
   end

   assign bus.rgb          = rgb_r;
   assign bus.frame_commit = frame_commit_r;

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Directed plus randomized checks of vga_cursor_overlay against a screen-level
// reference model (sprite drawn from text art, commit rules applied per step).
module tb_vga_cursor_overlay;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   vga_cursor_overlay_if vif();

   vga_cursor_overlay dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif)
   );

   int compared = 0;
   int mismatched = 0;

   int          m_ax, m_ay, m_px, m_py;
   logic [2:0]  m_abtn, m_pbtn;
   bit          m_dirty;
   logic [11:0] m_rgb;
   logic        m_fc;

   string sprite [16] = '{
      "O...............",
      "OO..............",
      "OFO.............",
      "OFFO............",
      "OFFFO...........",
      "OFFFFO..........",
      "OFFFFFO.........",
      "OFFFFFFO........",
      "OFFFFFFFO.......",
      "OFFFFFFFFO......",
      "OFFFFFOOOOO.....",
      "OFFOFFO.........",
      "OFO.OFFO........",
      "OO...OFFO.......",
      "O.....OFFO......",
      ".......OO......."
   };

   function automatic logic [11:0] ref_pixel(input int x, input int y);
      int c, r;
      logic [11:0] bg, px;
      byte ch;
      c  = x + 1;
      r  = y;
      bg = ((c % 64 == 0) || (r % 64 == 0)) ? 12'h444 : 12'h000;
      px = bg;
`ifdef VGA_CURSOR_CROSSHAIR_EN
      if (c == m_ax || r == m_ay) px = ~bg;
`endif
      if (c >= m_ax && c < m_ax + 16 && r >= m_ay && r < m_ay + 16) begin
         ch = sprite[r - m_ay].getc(c - m_ax);
         if (ch == "O") px = 12'h000;
         else if (ch == "F") px = (m_abtn != 3'd0) ? 12'hF00 : 12'hFFF;
      end
      return px;
   endfunction

   task automatic model_reset();
      m_ax = 320; m_ay = 240; m_px = 320; m_py = 240;
      m_abtn = 3'd0; m_pbtn = 3'd0; m_dirty = 1'b0;
      m_rgb = 12'h000; m_fc = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      compared++;
      assert (vif.rgb === m_rgb) else begin
         mismatched++;
         $error("FAIL %s rgb observed=%h expected=%h", tag, vif.rgb, m_rgb);
      end
      compared++;
      assert (vif.frame_commit === m_fc) else begin
         mismatched++;
         $error("FAIL %s frame_commit observed=%b expected=%b", tag, vif.frame_commit, m_fc);
      end
   endtask

   task automatic step(input bit tk, input int x, input int y, input bit von,
                       input bit cv, input int cx, input int cy, input logic [2:0] btn,
                       input string tag);
      @(negedge clk);
      vif.pixel_tick   = tk;
      vif.pixel_x      = 10'(x);
      vif.pixel_y      = 10'(y);
      vif.video_on     = von;
      vif.cursor_valid = cv;
      vif.cursor_x     = 10'(cx);
      vif.cursor_y     = 10'(cy);
      vif.buttons      = btn;
      m_fc = 1'b0;
      if (tk) begin
         m_rgb = von ? ref_pixel(x, y) : 12'h000;
         if (x == 0 && y == 480 && m_dirty) begin
            m_ax = m_px; m_ay = m_py; m_abtn = m_pbtn;
            m_dirty = 1'b0;
            m_fc = 1'b1;
         end
      end
      if (cv) begin
         m_px = (cx > 639) ? 639 : cx;
         m_py = (cy > 479) ? 479 : cy;
         m_pbtn = btn;
         m_dirty = 1'b1;
      end
      @(negedge clk);
      vif.pixel_tick   = 1'b0;
      vif.cursor_valid = 1'b0;
      check_outputs(tag);
   endtask

   task automatic tick(input int x, input int y, input bit von, input string tag);
      step(1'b1, x, y, von, 1'b0, 0, 0, 3'd0, tag);
   endtask

   task automatic strobe(input int cx, input int cy, input logic [2:0] btn, input string tag);
      step(1'b0, 0, 0, 1'b0, 1'b1, cx, cy, btn, tag);
   endtask

   task automatic commit(input string tag);
      tick(0, 480, 1'b0, tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs(tag);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int x, y, sel;
      vif.pixel_tick = 1'b0; vif.video_on = 1'b0;
      vif.pixel_x = 10'd0; vif.pixel_y = 10'd0;
      vif.cursor_x = 10'd0; vif.cursor_y = 10'd0;
      vif.buttons = 3'd0; vif.cursor_valid = 1'b0;
      #2;
      do_reset("reset_initial");

      // Home position after reset
      tick(320, 242, 1'b1, "home_fill");
      tick(318, 240, 1'b1, "home_left_of_hotspot");
      tick(63, 5, 1'b1, "grid_64_5");
      step(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 3'd0, "hold_between_ticks");

      // Move: strobe during visible frame, old position still drawn until commit
      step(1'b1, 5, 200, 1'b1, 1'b1, 100, 50, 3'd0, "move_strobe");
      tick(320, 242, 1'b1, "move_old_still_drawn");
      commit("move_commit");
      tick(100, 52, 1'b1, "move_new_fill");
      tick(320, 242, 1'b1, "move_old_gone");
      commit("no_commit_when_clean");

      // Crosshair column at ActX=100, row 300
      tick(99, 300, 1'b1, "crosshair_col");

      // Clamp and overwrite
      strobe(700, 600, 3'd0, "clamp_strobe_a");
      strobe(630, 470, 3'd0, "clamp_strobe_b");
      commit("overwrite_commit");
      tick(630, 472, 1'b1, "overwrite_fill");
      strobe(700, 600, 3'd0, "clamp_strobe_c");
      commit("clamp_commit");
      tick(638, 481, 1'b1, "clamp_edge_col");
      tick(639, 481, 1'b1, "clamp_past_edge");

      // Commit collision
      strobe(200, 200, 3'd0, "collide_pending");
      step(1'b1, 0, 480, 1'b0, 1'b1, 10, 10, 3'd0, "collide_commit1");
      tick(200, 202, 1'b1, "collide_first_pos");
      commit("collide_commit2");
      tick(10, 12, 1'b1, "collide_second_pos");

      // Buttons
      strobe(400, 300, 3'b001, "btn_press");
      commit("btn_commit");
      tick(400, 302, 1'b1, "btn_pressed_fill");
      strobe(400, 300, 3'b000, "btn_release");
      commit("btn_commit2");
      tick(400, 302, 1'b1, "btn_released_fill");
      tick(63, 5, 1'b1, "grid_cursor_elsewhere");

      // Blanking
      tick(400, 302, 1'b0, "blank_cursor");
      tick(63, 5, 1'b0, "blank_grid");

      // Reset mid-frame while rgb is lit and frame_commit is high
      strobe(0, 470, 3'd0, "pre_reset_strobe");
      commit("pre_reset_commit");
      strobe(5, 5, 3'd0, "pre_reset_strobe2");
      step(1'b1, 0, 480, 1'b1, 1'b0, 0, 0, 3'd0, "pre_reset_lit_commit");
      do_reset("reset_midframe");
      tick(320, 242, 1'b1, "post_reset_home");
      commit("post_reset_clean");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 11));
         case (sel)
            0: strobe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      3'($urandom_range(0, 7)), "rnd_strobe");
            1: commit("rnd_commit");
            2: step(1'b1, 0, 480, 1'($urandom_range(0, 1)), 1'b1,
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    3'($urandom_range(0, 7)), "rnd_collide");
            3: step(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 3'd0, "rnd_idle");
            4: tick(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                    1'b1, "rnd_any_pixel");
            default: begin
               x = m_ax - 2 + int'($urandom_range(0, 19));
               y = m_ay - 2 + int'($urandom_range(0, 19));
               if (x < 0) x = 0;
               if (x > 799) x = 799;
               if (y < 0) y = 0;
               if (y > 524) y = 524;
               tick(x, y, ($urandom_range(0, 3) != 0), "rnd_near_cursor");
            end
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vga_cursor_overlay.md
# vga_cursor_overlay

- Pixel source for the VGA output stage: consumes the sync generator's pixel coordinates and produces the 12-bit RGB word it drives onto the VGA lines.
- Draws a 64-pixel background grid with a 16×16 arrow mouse cursor composited on top.
- Cursor position and button updates from the mouse controller are double-buffered and committed only at the start of vertical blanking, so the cursor never tears.

## Interface

Parameters:
- BG_COLOR, 12'h000: background fill.
- GRID_COLOR, 12'h444: grid line colour.
- FILL_COLOR, 12'hFFF: cursor fill, no button pressed.
- FILL_PRESSED, 12'hF00: cursor fill, any button pressed.
- OUTLINE_COLOR, 12'h000: cursor outline.

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: asynchronous, active-low reset.
- PixelTick, input, 1: one-cycle pixel enable from the sync generator.
- VideoOn, input, 1: visible-area flag.
- PixelX, input, 10: current column, 0..799.
- PixelY, input, 10: current row, 0..524.
- CursorX, input, 10: new cursor column from the mouse controller.
- CursorY, input, 10: new cursor row.
- Buttons, input, 3: button state {M,R,L}.
- CursorValid, input, 1: one-cycle strobe; CursorX/CursorY/Buttons are valid.
- RGB, output, 12: pixel colour {R[3:0],G[3:0],B[3:0]}, registered.
- FrameCommit, output, 1: one-cycle pulse when pending values are committed.

## Operation

- **Pending registers (PendX, PendY, PendBtn, PendDirty).**
  - On CursorValid, load CursorX clamped to 639 and CursorY clamped to 479.
  - Load Buttons; set PendDirty.
  - Later strobes overwrite earlier ones; the last strobe wins.
- **Commit point.** The first cycle with PixelTick=1, PixelX=0 and PixelY=480.
  - If PendDirty=1: copy the pending registers to the active registers (ActX, ActY, ActBtn), clear PendDirty, and pulse FrameCommit the next cycle.
  - If PendDirty=0: no copy and no pulse.
- **CursorValid in the same cycle as the commit point.** The commit uses the old pending contents. The new value lands in pending, PendDirty stays 1, and it commits next frame.
- **Render column.** The pixel is computed for column C = PixelX+1 and row R = PixelY. This compensates for the one-tick output register.
- **Background.**
  - GRID_COLOR when C[5:0]==0 or R[5:0]==0.
  - Otherwise BG_COLOR.
- **Cursor.** The hotspot is the sprite's top-left pixel.
  - The cursor covers the pixel if dx = C-ActX and dy = R-ActY are both in 0..15. Use unsigned 10-bit subtraction; a wrapped (negative) difference fails the <16 test.
  - An internal 16-row ROM holds 2 bits per pixel: 00 transparent, 01 outline, 10 fill.
  - Outline pixels use OUTLINE_COLOR.
  - Fill pixels use FILL_PRESSED if ActBtn≠0, else FILL_COLOR.
  - Transparent pixels show the layer below.
- **Layer order.** Cursor over crosshair (when compiled in) over background.
- **Screen edges.** The sprite clips naturally at the right and bottom edges; no wrap to column 0 or row 0.
- **Output.** On PixelTick, RGB ← composite if VideoOn=1, else 12'h000. RGB holds between ticks.

## Timing

- **Reset (asynchronous):**
  - RGB=0, FrameCommit=0, PendDirty=0.
  - ActX=PendX=320, ActY=PendY=240, ActBtn=PendBtn=0.
- **Reset mid-frame:** clears all state at once. The first commit can occur at the next row-480 point after release.
- **Latency:**
  - RGB updates in the cycle after PixelTick.
  - An accepted CursorValid becomes visible in the first full frame after the commit point.
  - Worst case is just under two frames.
- **Pipeline:** the RGB path is one register stage; the ROM read is combinational.

## Configuration

- Macro: VGA_CURSOR_CROSSHAIR_EN.
- **Defined:**
  - Pixels with C==ActX or R==ActY, across the full visible area, use the inverted colour of the underlying background layer (~bg).
  - The crosshair is drawn under the cursor sprite.
- **Undefined:** no crosshair logic is generated; output depends only on background and cursor.

## Test plan

- **Reset:** assert Reset_n=0 mid-line → RGB=000 and FrameCommit=0 immediately. After release, the cursor's first outline pixel appears at (320,240).
- **Move:** CursorValid with X=100, Y=50 at row 200 → the current frame still draws the cursor at 320,240. FrameCommit pulses at row 480. The next frame draws it at 100,50.
- **Clamp and overwrite:** two strobes in one frame, (700,600) then (630,470) → commits 630,470. A single (700,600) strobe → commits 639,479, and only one cursor column is visible.
- **Commit collision:** strobe (10,10) exactly on the commit tick, with pending (200,200) dirty → commits 200,200 this frame and 10,10 next frame; two FrameCommit pulses total.
- **Buttons:** Buttons=3'b001 committed → fill pixels read 12'hF00. Buttons=0 → 12'hFFF. Grid pixel at (64,5) reads 12'h444 when the cursor is elsewhere.
- **Blanking and crosshair:** VideoOn=0 → RGB=000 for the whole blank. With VGA_CURSOR_CROSSHAIR_EN and ActX=100, pixel (100,300) reads 12'hFFF on BG_COLOR=000; without the macro it reads 12'h000.
